// File: rtl/uart_mem_loader.sv
// Byte-stream boot loader: parses framed UART commands into word writes/reads on a
// req/gnt/rvalid memory port, streams read data back on TX and drives core fetch-enable.
module uart_mem_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_BYTES      = 2,
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    fetch_en_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int AB = ADDR_WIDTH / 8;
    localparam int DB = DATA_WIDTH / 8;
    localparam int CW = 8 * CNT_BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WREQ, S_RREQ, S_RWAIT, S_RSEND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [7:0]            byte_cnt_q;
    logic [31:0]           tmo_q;
    logic                  is_write_q;
    logic                  fetch_q;
    logic                  err_q;

    // Fields arrive in the configured byte order; shift so the final layout is natural.
    function automatic logic [ADDR_WIDTH-1:0] put_addr(input logic [ADDR_WIDTH-1:0] r,
                                                       input logic [7:0] b);
        if (BIG_ENDIAN != 0) return (r << 8) | ADDR_WIDTH'(b);
        return (r >> 8) | (ADDR_WIDTH'(b) << (ADDR_WIDTH - 8));
    endfunction

    function automatic logic [CW-1:0] put_cnt(input logic [CW-1:0] r, input logic [7:0] b);
        if (BIG_ENDIAN != 0) return (r << 8) | CW'(b);
        return (r >> 8) | (CW'(b) << (CW - 8));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] put_data(input logic [DATA_WIDTH-1:0] r,
                                                       input logic [7:0] b);
        if (BIG_ENDIAN != 0) return (r << 8) | DATA_WIDTH'(b);
        return (r >> 8) | (DATA_WIDTH'(b) << (DATA_WIDTH - 8));
    endfunction

    logic          in_frame;
    logic          tmo_hit;
    logic          last_addr_byte;
    logic          last_cnt_byte;
    logic          last_data_byte;
    logic          last_word;
    logic [CW-1:0] cnt_asm;

    assign in_frame       = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_WDATA);
    assign tmo_hit        = (TIMEOUT_CYCLES != 0) && in_frame && !rx_valid &&
                            (tmo_q == 32'(TIMEOUT_CYCLES));
    assign last_addr_byte = (byte_cnt_q == 8'(AB - 1));
    assign last_cnt_byte  = (byte_cnt_q == 8'(CNT_BYTES - 1));
    assign last_data_byte = (byte_cnt_q == 8'(DB - 1));
    assign last_word      = (cnt_q == CW'(1));
    assign cnt_asm        = put_cnt(cnt_q, rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Handshake inputs are used directly here (the matching ready/valid is implied by
    // the state) so the outputs decoded below do not feed back into this block.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid && (rx_data == 8'h02 || rx_data == 8'h03)) state_d = S_ADDR;
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid && last_addr_byte) state_d = S_CNT;
                else if (tmo_hit)               state_d = S_IDLE;
            end
            S_CNT: begin
                rx_ready = 1'b1;
                if (rx_valid && last_cnt_byte) begin
                    if (cnt_asm == '0)   state_d = S_IDLE;
                    else if (is_write_q) state_d = S_WDATA;
                    else                 state_d = S_RREQ;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WDATA: begin
                rx_ready = 1'b1;
                if (rx_valid && last_data_byte) state_d = S_WREQ;
                else if (tmo_hit)               state_d = S_IDLE;
            end
            S_WREQ: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) state_d = last_word ? S_IDLE : S_WDATA;
            end
            S_RREQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (mem_rvalid) state_d = S_RSEND;
            end
            S_RSEND: begin
                tx_valid = 1'b1;
                if (tx_ready && last_data_byte) state_d = last_word ? S_IDLE : S_RREQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            tx_shift_q <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            is_write_q <= 1'b0;
            fetch_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (TIMEOUT_CYCLES != 0 && in_frame && !rx_valid && !tmo_hit) tmo_q <= tmo_q + 32'd1;
            else                                                          tmo_q <= '0;
            if (tmo_hit) err_q <= 1'b1;

            case (state_q)
                S_IDLE: if (rx_valid) begin
                    case (rx_data)
                        8'h02:   begin is_write_q <= 1'b1; byte_cnt_q <= '0; end
                        8'h03:   begin is_write_q <= 1'b0; byte_cnt_q <= '0; end
                        8'h0F:   fetch_q <= 1'b1;
                        8'h0E:   begin fetch_q <= 1'b0; err_q <= 1'b0; end
                        default: err_q <= 1'b1;
                    endcase
                end
                S_ADDR: if (rx_valid) begin
                    addr_q     <= put_addr(addr_q, rx_data);
                    byte_cnt_q <= last_addr_byte ? '0 : byte_cnt_q + 8'd1;
                end
                S_CNT: if (rx_valid) begin
                    cnt_q      <= cnt_asm;
                    byte_cnt_q <= last_cnt_byte ? '0 : byte_cnt_q + 8'd1;
                end
                S_WDATA: if (rx_valid) begin
                    wdata_q    <= put_data(wdata_q, rx_data);
                    byte_cnt_q <= last_data_byte ? '0 : byte_cnt_q + 8'd1;
                end
                S_WREQ: if (mem_gnt) begin
                    addr_q <= addr_q + ADDR_WIDTH'(DB);
                    cnt_q  <= cnt_q - CW'(1);
                end
                S_RWAIT: if (mem_rvalid) begin
                    tx_shift_q <= mem_rdata;
                    byte_cnt_q <= '0;
                end
                S_RSEND: if (tx_ready) begin
                    tx_shift_q <= (BIG_ENDIAN != 0) ? (tx_shift_q << 8) : (tx_shift_q >> 8);
                    if (last_data_byte) begin
                        byte_cnt_q <= '0;
                        addr_q     <= addr_q + ADDR_WIDTH'(DB);
                        cnt_q      <= cnt_q - CW'(1);
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data    = (BIG_ENDIAN != 0) ? tx_shift_q[DATA_WIDTH-1 -: 8] : tx_shift_q[7:0];
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_be     = '1;
    assign fetch_en_o = fetch_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

endmodule
